// File: rtl/uart_receiver_pkg.sv
// Shared definitions for the UART receive path.
// Holds the receiver FSM state encodings and the default bit period, which is
// the same value the UART transmitter uses so the two ends stay in lockstep.
package uart_receiver_pkg;

    // Receiver FSM states; the encodings are visible on the debug state port.
    typedef enum logic [1:0] {
        RX_STATE_IDLE  = 2'd0,
        RX_STATE_START = 2'd1,
        RX_STATE_DATA  = 2'd2,
        RX_STATE_STOP  = 2'd3
    } rx_state_e;

    // Default clk cycles per UART bit, shared with the transmitter.
    localparam int UART_CLKS_PER_BIT = 279;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial RX line.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset; both flops reset to 1 (line idle)
//   din  - raw serial input, asynchronous to clk
//   dout - synchronized line value
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic meta_r;
    logic sync_r;

    // Two-stage resynchronization of din into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
        end else begin
            meta_r <= din;
            sync_r <= meta_r;
        end
    end

    assign dout = sync_r;

endmodule

// File: rtl/uart_receiver.sv
// UART receiver, 8N1, LSB first, idle-high line.
// Samples each bit at its centre: the start bit is re-checked half a bit after
// the falling edge, then every following bit one full bit period later.
// Ports:
//   clk       - system clock, all logic on posedge
//   rst       - asynchronous active-high reset
//   din       - serial line (asynchronous, idle = 1)
//   data_rx   - last good byte, held until the next good byte
//   valid     - 1-cycle pulse when data_rx is updated
//   frame_err - 1-cycle pulse when the stop bit was sampled 0 (byte dropped)
//   busy      - 1 while a frame is in progress
//   state     - FSM state, debug only
module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int CNT_W        = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    output logic [7:0] data_rx,
    output logic       valid,
    output logic       frame_err,
    output logic       busy,
    output logic [1:0] state
);

    localparam logic [CNT_W-1:0] HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic             rxs_s;
    rx_state_e        state_r,  state_nxt_s;
    logic [CNT_W-1:0] cnt_r,    cnt_nxt_s;
    logic [2:0]       idx_r,    idx_nxt_s;
    logic [7:0]       shift_r,  shift_nxt_s;
    logic [7:0]       data_r,   data_nxt_s;
    logic             valid_r,  valid_nxt_s;
    logic             ferr_r,   ferr_nxt_s;
    logic             armed_r,  armed_nxt_s;
    logic             busy_r;

    uart_rx_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .dout (rxs_s)
    );

    // State, datapath and registered output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= RX_STATE_IDLE;
            cnt_r   <= '0;
            idx_r   <= 3'd0;
            shift_r <= 8'd0;
            data_r  <= 8'd0;
            valid_r <= 1'b0;
            ferr_r  <= 1'b0;
            armed_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            idx_r   <= idx_nxt_s;
            shift_r <= shift_nxt_s;
            data_r  <= data_nxt_s;
            valid_r <= valid_nxt_s;
            ferr_r  <= ferr_nxt_s;
            armed_r <= armed_nxt_s;
            busy_r  <= (state_nxt_s != RX_STATE_IDLE);
        end
    end

    // Next-state, bit counter, shift register and output strobe logic.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        idx_nxt_s   = idx_r;
        shift_nxt_s = shift_r;
        data_nxt_s  = data_r;
        valid_nxt_s = 1'b0;
        ferr_nxt_s  = 1'b0;
        armed_nxt_s = armed_r;

        case (state_r)
            RX_STATE_IDLE: begin
                cnt_nxt_s = '0;
                idx_nxt_s = 3'd0;
                // A low line is only a start once the line has been seen idle,
                // so a reset or break in the middle of low data cannot start a frame.
                if (armed_r && !rxs_s) begin
                    state_nxt_s = RX_STATE_START;
                    armed_nxt_s = 1'b0;
                end else if (rxs_s) begin
                    armed_nxt_s = 1'b1;
                end else begin
                    armed_nxt_s = armed_r;
                end
            end

            RX_STATE_START: begin
                if (cnt_r == HALF) begin
                    cnt_nxt_s = '0;
                    if (!rxs_s) begin
                        state_nxt_s = RX_STATE_DATA;
                    end else begin
                        state_nxt_s = RX_STATE_IDLE;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end

            RX_STATE_DATA: begin
                if (cnt_r == LAST) begin
                    cnt_nxt_s          = '0;
                    shift_nxt_s[idx_r] = rxs_s;
                    if (idx_r == 3'd7) begin
                        state_nxt_s = RX_STATE_STOP;
                        idx_nxt_s   = 3'd0;
                    end else begin
                        idx_nxt_s = idx_r + 3'd1;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end

            RX_STATE_STOP: begin
                // Decide at mid stop bit; returning to IDLE half a bit early
                // lets a back-to-back start edge be caught.
                if (cnt_r == LAST) begin
                    cnt_nxt_s   = '0;
                    state_nxt_s = RX_STATE_IDLE;
                    if (rxs_s) begin
                        data_nxt_s  = shift_r;
                        valid_nxt_s = 1'b1;
                    end else begin
                        ferr_nxt_s = 1'b1;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end

            default: begin
                state_nxt_s = RX_STATE_IDLE;
                cnt_nxt_s   = '0;
                idx_nxt_s   = 3'd0;
            end
        endcase
    end

    assign data_rx   = data_r;
    assign valid     = valid_r;
    assign frame_err = ferr_r;
    assign busy      = busy_r;
    assign state     = state_r;

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: the frame driver pushes the expected
// outcome of each frame, a monitor pops one entry per valid/frame_err pulse.
module tb_uart_receiver;

    localparam int P       = 279;
    localparam int LAT_MIN = 2652;
    localparam int LAT_MAX = 2656;

    typedef struct {
        logic       err;
        logic [7:0] data;
        int         start;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       din;
    logic [7:0] data_rx;
    logic       valid;
    logic       frame_err;
    logic       busy;
    logic [1:0] state;

    exp_t       exp_q[$];
    int         total;
    int         bad;
    int         cyc;
    logic [7:0] last_good;

    uart_receiver dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .data_rx   (data_rx),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    // Monitor: every output pulse must match the oldest expected frame outcome.
    always @(negedge clk) begin
        exp_t e;
        int   lat;
        if (!rst && (valid || frame_err)) begin
            check("valid_and_err_exclusive", int'(valid & frame_err), 0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: valid=%0d frame_err=%0d data_rx=0x%0h at cycle %0d, none expected",
                         valid, frame_err, data_rx, cyc);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind_err", int'(frame_err), int'(e.err));
                if (!e.err) last_good = e.data;
                check("data_rx", int'(data_rx), int'(last_good));
                lat = cyc - e.start;
                total++;
                if (lat < LAT_MIN || lat > LAT_MAX) begin
                    bad++;
                    $display("FAIL latency: got %0d cycles expected %0d..%0d", lat, LAT_MIN, LAT_MAX);
                end
            end
        end
    end

    task automatic drive_bit(input logic v, input int period);
        @(negedge clk);
        din = v;
        repeat (period - 1) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input int period, input logic stop_bit);
        exp_t e;
        @(negedge clk);
        din     = 1'b0;
        e.err   = ~stop_bit;
        e.data  = b;
        e.start = cyc;
        exp_q.push_back(e);
        repeat (period - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) drive_bit(b[i], period);
        drive_bit(stop_bit, period);
    endtask

    task automatic idle_gap(input int n);
        @(negedge clk);
        din = 1'b1;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(negedge clk);
        check(name, exp_q.size(), 0);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #(2000000 * 10);
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b81;
        total     = 0;
        bad       = 0;
        cyc       = 0;
        last_good = 8'h00;
        din       = 1'b1;
        rst       = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_state", int'(state), 0);
        check("reset_data_rx", int'(data_rx), 0);
        check("reset_flags", int'({valid, frame_err, busy}), 0);
        rst = 1'b0;
        idle_gap(20);

        // Plain bytes with idle gaps.
        send_frame(8'hA5, P, 1'b1);
        idle_gap(2 * P);
        send_frame(8'h00, P, 1'b1);
        idle_gap(2 * P);
        send_frame(8'hFF, P, 1'b1);
        idle_gap(2 * P);

        // Back-to-back frames, no idle gap.
        send_frame(8'h3C, P, 1'b1);
        send_frame(8'hC3, P, 1'b1);
        idle_gap(2 * P);
        drain("drain_after_b2b");

        // Short low glitch while idle.
        @(negedge clk);
        din = 1'b0;
        repeat (99) @(negedge clk);
        idle_gap(3 * P);
        check("glitch_state_idle", int'(state), 0);
        check("glitch_busy", int'(busy), 0);

        // Bad stop bit, then a long break, then recovery.
        send_frame(8'h55, P, 1'b0);
        repeat (5000) @(negedge clk);
        check("break_state_idle", int'(state), 0);
        idle_gap(2 * P);
        send_frame(8'h12, P, 1'b1);
        idle_gap(2 * P);
        drain("drain_after_break");

        // Reset in the middle of bit 4 of 0x81.
        b81 = 8'h81;
        drive_bit(1'b0, P);
        for (int i = 0; i < 4; i++) drive_bit(b81[i], P);
        @(negedge clk);
        din = b81[4];
        repeat (P / 2) @(negedge clk);
        check("pre_reset_state_data", int'(state), 2);
        rst       = 1'b1;
        last_good = 8'h00;
        #1;
        check("midreset_state", int'(state), 0);
        check("midreset_outputs", int'({data_rx, valid, frame_err, busy}), 0);
        repeat (P - P / 2 - 1) @(negedge clk);
        for (int i = 5; i < 7; i++) drive_bit(b81[i], P);
        @(negedge clk);
        din = b81[7];
        repeat (P / 2) @(negedge clk);
        rst = 1'b0;
        repeat (P - P / 2 - 1) @(negedge clk);
        drive_bit(1'b1, P);
        idle_gap(2 * P);
        check("after_abort_no_pulse", exp_q.size(), 0);
        send_frame(8'h81, P, 1'b1);
        idle_gap(2 * P);

        // Bit period skewed by about +/-2%.
        send_frame(8'h6B, 273, 1'b1);
        send_frame(8'h94, 273, 1'b1);
        idle_gap(2 * P);
        send_frame(8'hD2, 285, 1'b1);
        send_frame(8'h2D, 285, 1'b1);
        idle_gap(2 * P);
        drain("drain_final");
        check("final_data_rx", int'(data_rx), 8'h2D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
